// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster defaults, derived totals and the renderer coordinate type.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int MAX_TOTAL      = 1024;
    localparam int MAX_SYNC_DELAY = 4;

    function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = timing_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL = timing_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage 1-bit shift register with every stage reset to RST_VAL; DEPTH 0 is a plain wire.
module sync_delay_line #(
    parameter int DEPTH   = 1,
    parameter bit RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_q = i_d;
        end else begin : g_chain
            logic [DEPTH-1:0] r_stage;
            // Shift toward the output; reset flushes every stage so no stale pulse survives
            always_ff @(posedge i_clk) begin
                if (i_rst) r_stage <= {DEPTH{RST_VAL}};
                else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end
            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters driving DrawX/DrawY/blank for the renderers plus hs/vs delayed to match their RGB register.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic        line_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);
    localparam int HT = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int VT = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_ON  = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_OFF = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(HT - 1);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_ON  = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_OFF = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST     = 11'(VT - 1);

    generate
        if (HT > MAX_TOTAL || VT > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be within 0..4");
        end
    endgenerate

    coord_t      r_hc;
    coord_t      r_vc;
    logic [10:0] w_hx;
    logic [10:0] w_vy;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_hs_dly;
    logic        w_vs_dly;

    // Decode wraps, visibility and raw (active-high) syncs from the current counters; reset masks everything
    always_comb begin
        w_hx     = {1'b0, r_hc};
        w_vy     = {1'b0, r_vc};
        w_h_wrap = (w_hx == H_LAST);
        w_v_wrap = w_h_wrap && (w_vy == V_LAST);
        w_hs_raw = !reset && (w_hx >= H_SYNC_ON) && (w_hx < H_SYNC_OFF);
        w_vs_raw = !reset && (w_vy >= V_SYNC_ON) && (w_vy < V_SYNC_OFF);
    end

    // Pixel counter runs every cycle; line counter steps only when the pixel counter wraps
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else begin
            r_hc <= w_h_wrap ? '0 : r_hc + 10'd1;
            if (w_h_wrap) r_vc <= w_v_wrap ? '0 : r_vc + 10'd1;
        end
    end

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b0)) u_hs_dly (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_d   (w_hs_raw),
        .o_q   (w_hs_dly)
    );

    sync_delay_line #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b0)) u_vs_dly (
        .i_clk (vga_clk),
        .i_rst (reset),
        .i_d   (w_vs_raw),
        .o_q   (w_vs_dly)
    );

    // Scan outputs are zero-latency views of the counters; polarity is applied after the sync delay
    always_comb begin
        DrawX       = r_hc;
        DrawY       = r_vc;
        blank       = !reset && (w_hx < H_VIS_END) && (w_vy < V_VIS_END);
        line_start  = !reset && (r_hc == '0);
        frame_start = !reset && (r_hc == '0) && (r_vc == '0);
        hs          = HS_POL ? w_hs_dly : ~w_hs_dly;
        vs          = VS_POL ? w_vs_dly : ~w_vs_dly;
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    // Count completed frames; the increment lands together with the frame_start pulse
    always_ff @(posedge vga_clk) begin
        r_frame_cnt <= reset ? '0 : r_frame_cnt + {15'd0, w_v_wrap};
    end
    assign frame_count = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for two vga_timing_gen builds (defaults, and a tiny raster with zero delay and active-high syncs).
module tb_vga_timing_gen;

    localparam int HV[2]  = '{640, 20};
    localparam int HFP[2] = '{16, 3};
    localparam int HSW[2] = '{96, 5};
    localparam int HBP[2] = '{48, 4};
    localparam int VV[2]  = '{480, 12};
    localparam int VFP[2] = '{10, 2};
    localparam int VSW[2] = '{2, 2};
    localparam int VBP[2] = '{33, 3};
    localparam int DLY[2] = '{1, 0};
    localparam bit HP[2]  = '{1'b0, 1'b1};
    localparam bit VP[2]  = '{1'b0, 1'b1};

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        b;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [9:0] x0, y0, x1, y1;
    logic b0, hs0, vs0, fs0, ls0, b1, hs1, vs1, fs1, ls1;
    logic [15:0] fc0, fc1;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk = 0;
    int n_fail = 0;

    int p[2];
    int fc[2];
    bit rawh[2][5];
    bit rawv[2][5];
    bit rsth[5];

    always #5 clk = ~clk;

    vga_timing_gen dut0 (
        .vga_clk     (clk),
        .reset       (reset),
        .DrawX       (x0),
        .DrawY       (y0),
        .blank       (b0),
        .hs          (hs0),
        .vs          (vs0),
        .frame_start (fs0),
        .line_start  (ls0)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (fc0)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .SYNC_DELAY(0)
    ) dut1 (
        .vga_clk     (clk),
        .reset       (reset),
        .DrawX       (x1),
        .DrawY       (y1),
        .blank       (b1),
        .hs          (hs1),
        .vs          (vs1),
        .frame_start (fs1),
        .line_start  (ls1)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_count (fc1)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc0 = '0;
    assign fc1 = '0;
`endif

    function automatic int htot(input int i);
        return HV[i] + HFP[i] + HSW[i] + HBP[i];
    endfunction

    function automatic int vtot(input int i);
        return VV[i] + VFP[i] + VSW[i] + VBP[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the frame-position model on the edge, drive the next reset level, push expectations
    task automatic step(input logic r);
        exp_t e;
        int ht, vt, x, y, d;
        bit hact, vact;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                p[i] = 0;
                fc[i] = 0;
            end else begin
                if (p[i] == htot(i) * vtot(i) - 1) fc[i] = (fc[i] + 1) % 65536;
                p[i] = (p[i] + 1) % (htot(i) * vtot(i));
            end
        end
        #1 reset = r;
        for (int j = 4; j > 0; j--) rsth[j] = rsth[j-1];
        rsth[0] = r;
        for (int i = 0; i < 2; i++) begin
            ht = htot(i);
            vt = vtot(i);
            x = p[i] % ht;
            y = p[i] / ht;
            d = DLY[i];
            for (int j = 4; j > 0; j--) begin
                rawh[i][j] = rawh[i][j-1];
                rawv[i][j] = rawv[i][j-1];
            end
            rawh[i][0] = !r && x >= HV[i] + HFP[i] && x < HV[i] + HFP[i] + HSW[i];
            rawv[i][0] = !r && y >= VV[i] + VFP[i] && y < VV[i] + VFP[i] + VSW[i];
            hact = rawh[i][d];
            vact = rawv[i][d];
            for (int j = 1; j <= d; j++) if (rsth[j]) begin
                hact = 1'b0;
                vact = 1'b0;
            end
            e.x  = 10'(x);
            e.y  = 10'(y);
            e.b  = !r && x < HV[i] && y < VV[i] && y < vt;
            e.ls = !r && x == 0;
            e.fs = !r && p[i] == 0;
            e.hs = hact ? HP[i] : !HP[i];
            e.vs = vact ? VP[i] : !VP[i];
            e.fc = 16'(fc[i]);
            if (i == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic run_to_x(input int i, input int xt);
        for (int n = 0; n < 2000 && (p[i] % htot(i)) != xt; n++) step(1'b0);
    endtask

    // Monitor: every cycle the DUTs present a pixel; compare it against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("d0.DrawX", 32'(x0), 32'(e.x));
                chk("d0.DrawY", 32'(y0), 32'(e.y));
                chk("d0.blank", 32'(b0), 32'(e.b));
                chk("d0.hs", 32'(hs0), 32'(e.hs));
                chk("d0.vs", 32'(vs0), 32'(e.vs));
                chk("d0.frame_start", 32'(fs0), 32'(e.fs));
                chk("d0.line_start", 32'(ls0), 32'(e.ls));
`ifdef VGA_FRAME_CNT_EN
                chk("d0.frame_count", 32'(fc0), 32'(e.fc));
`endif
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("d1.DrawX", 32'(x1), 32'(e.x));
                chk("d1.DrawY", 32'(y1), 32'(e.y));
                chk("d1.blank", 32'(b1), 32'(e.b));
                chk("d1.hs", 32'(hs1), 32'(e.hs));
                chk("d1.vs", 32'(vs1), 32'(e.vs));
                chk("d1.frame_start", 32'(fs1), 32'(e.fs));
                chk("d1.line_start", 32'(ls1), 32'(e.ls));
`ifdef VGA_FRAME_CNT_EN
                chk("d1.frame_count", 32'(fc1), 32'(e.fc));
`endif
            end
        end
    end

    initial begin
        for (int j = 0; j < 5; j++) rsth[j] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p[i] = 0;
            fc[i] = 0;
            for (int j = 0; j < 5; j++) begin
                rawh[i][j] = 1'b0;
                rawv[i][j] = 1'b0;
            end
        end
        repeat (5) step(1'b1);
        repeat (2600) step(1'b0);
        run_to_x(0, 299);
        step(1'b1);
        repeat (12) step(1'b0);
        run_to_x(0, 699);
        step(1'b1);
        repeat (12) step(1'b0);
        step(1'b1);
        step(1'b1);
        repeat (3 * 32 * 19 + 40) step(1'b0);
        repeat (40) begin
            repeat ($urandom_range(2000, 200)) step(1'b0);
            repeat ($urandom_range(3, 1)) step(1'b1);
        end
        repeat (1500) step(1'b0);
        @(negedge clk);
        #2;
        chk("d0.drain", 32'(q0.size()), 32'd0);
        chk("d1.drain", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
